// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding selects, load-use / branch stall and flush
// generation, and sequencing of fixed-latency multi-cycle execute operations.
module hazard_ctrl #(
  parameter int MC_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1_addr_d,
  input  logic [4:0]  rs2_addr_d,
  input  logic [4:0]  rs1_addr_e,
  input  logic [4:0]  rs2_addr_e,
  input  logic        valid_e,
  input  logic        mem_load_e,
  input  logic        rf_write_en_e,
  input  logic [4:0]  rf_dest_e,
  input  logic        mc_op_e,
  input  logic        branch_taken_e,
  input  logic        valid_m,
  input  logic        rf_write_en_m,
  input  logic [4:0]  rf_dest_m,
  input  logic        valid_w,
  input  logic        rf_write_en_w,
  input  logic [4:0]  rf_dest_w,
  output logic [1:0]  forward_rs1_select_e,
  output logic [1:0]  forward_rs2_select_e,
  output logic        stall_fetch,
  output logic        stall_decode,
  output logic        stall_execute,
  output logic        flush_decode,
  output logic        flush_execute,
  output logic        flush_memory,
  output logic        mc_done,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_e;

  mc_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       stall_cycles_q, stall_cycles_d;

  logic mem_hit_1, mem_hit_2, wb_hit_1, wb_hit_2;
  logic load_use, branch, mc_stall;

  // Forwarding: memory-stage producer has priority over writeback.
  always_comb begin
    mem_hit_1 = valid_m & rf_write_en_m & (rf_dest_m != 5'd0) & (rf_dest_m == rs1_addr_e);
    mem_hit_2 = valid_m & rf_write_en_m & (rf_dest_m != 5'd0) & (rf_dest_m == rs2_addr_e);
    wb_hit_1  = valid_w & rf_write_en_w & (rf_dest_w != 5'd0) & (rf_dest_w == rs1_addr_e);
    wb_hit_2  = valid_w & rf_write_en_w & (rf_dest_w != 5'd0) & (rf_dest_w == rs2_addr_e);
    forward_rs1_select_e = '0;
    forward_rs2_select_e = '0;
    if (!reset) begin
      forward_rs1_select_e = {mem_hit_1, wb_hit_1 & ~mem_hit_1};
      forward_rs2_select_e = {mem_hit_2, wb_hit_2 & ~mem_hit_2};
    end
  end

  // Multi-cycle sequencer next state and hazard priority: mc stall > branch > load-use.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mc_stall       = 1'b0;
    mc_done        = 1'b0;
    stall_fetch    = 1'b0;
    stall_decode   = 1'b0;
    stall_execute  = 1'b0;
    flush_decode   = 1'b0;
    flush_execute  = 1'b0;
    flush_memory   = 1'b0;

    // rs2 is compared even when unused; a spurious one-cycle stall is harmless.
    load_use = valid_e & mem_load_e & rf_write_en_e & (rf_dest_e != 5'd0) &
               ((rf_dest_e == rs1_addr_d) | (rf_dest_e == rs2_addr_d));
    branch   = valid_e & branch_taken_e;

    unique case (state_q)
      IDLE: begin
        if (valid_e && mc_op_e) begin
          mc_stall = 1'b1;
          cnt_d    = CNT_W'(MC_LATENCY - 2);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        mc_stall = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      DONE: begin
        mc_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (mc_stall) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      stall_execute = 1'b1;
      flush_memory  = 1'b1;
    end else if (branch) begin
      flush_decode  = 1'b1;
      flush_execute = 1'b1;
    end else if (load_use) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      flush_execute = 1'b1;
    end

    // Reset forces every output low for the reset cycle itself.
    if (reset) begin
      mc_done       = 1'b0;
      stall_fetch   = 1'b0;
      stall_decode  = 1'b0;
      stall_execute = 1'b0;
      flush_decode  = 1'b0;
      flush_execute = 1'b0;
      flush_memory  = 1'b0;
    end

    stall_cycles_d = stall_cycles_q + 32'(stall_decode);
    stall_cycles   = reset ? '0 : stall_cycles_q;
  end

  // State, counter and stall statistics registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage RISC-V core. It drives the execute stage's operand-forwarding selects. It generates the stall and flush controls for every pipeline register. It also sequences multi-cycle execute operations (iterative mul/div) by holding execute for a fixed latency and bubbling memory behind them. It sits beside the pipeline and consumes the execute-stage hazard bus fields plus the destination fields from the memory and writeback stages.

## Interface
- MC_LATENCY, 32: total execute-stage cycles a multi-cycle op occupies, including its entry and done cycles; legal range 3..63.
- CNT_W, 6: width of the multi-cycle down-counter.

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rs1_addr_d, rs2_addr_d  in  5 each  source registers of the decode-stage instruction
- rs1_addr_e, rs2_addr_e  in  5 each  source registers of the execute-stage instruction
- valid_e, mem_load_e, rf_write_en_e  in  1 each  execute-stage valid, is-load, writes-RF
- rf_dest_e  in  5  execute-stage destination
- mc_op_e  in  1  execute holds a multi-cycle op
- branch_taken_e  in  1  execute redirects fetch
- valid_m, rf_write_en_m  in  1 each; rf_dest_m  in  5  memory-stage producer
- valid_w, rf_write_en_w  in  1 each; rf_dest_w  in  5  writeback-stage producer
- forward_rs1_select_e, forward_rs2_select_e  out  2 each  bit1 = take memory result, bit0 = take writeback result
- stall_fetch, stall_decode, stall_execute  out  1 each  hold the stage register
- flush_decode, flush_execute, flush_memory  out  1 each  load a bubble into the stage register
- mc_done  out  1  final cycle of a multi-cycle op; its result is valid
- stall_cycles  out  32  count of cycles with stall_decode=1

## Operation
- Forwarding (combinational): mem_hit_x = valid_m & rf_write_en_m & rf_dest_m!=0 & rf_dest_m==rsx_addr_e.
  - wb_hit_x is the same using the writeback fields.
  - select = {mem_hit_x, wb_hit_x & ~mem_hit_x}; only 00, 01 and 10 are legal, and memory has priority.
- Load-use: lu = valid_e & mem_load_e & rf_write_en_e & rf_dest_e!=0 & (rf_dest_e==rs1_addr_d | rf_dest_e==rs2_addr_d).
  - Compares rs2 even when the instruction does not use it; this is deliberately conservative.
  - Response: stall_fetch=1, stall_decode=1, flush_execute=1. Lasts one cycle with no state.
- Branch: branch_taken_e & valid_e gives flush_decode=1 and flush_execute=1.
  - It overrides lu: no stalls are asserted, so fetch takes the redirect.
- Multi-cycle FSM, states IDLE, BUSY, DONE; cnt is CNT_W bits:
  - IDLE: if valid_e & mc_op_e, this is the entry cycle: assert mc stall, load cnt=MC_LATENCY-2, go to BUSY.
  - BUSY: assert mc stall. If cnt==1 go to DONE, else cnt--.
  - DONE: mc_done=1, no mc stall; the op advances at this edge. Go to IDLE unconditionally.
  - Mc stall: stall_fetch=stall_decode=stall_execute=1, flush_memory=1, flush_execute=0, flush_decode=0.
  - Mc stall overrides both lu and branch.
- mc_op_e and branch_taken_e are never both asserted. If both are, mc wins and the branch is ignored.
- stall_cycles increments each cycle stall_decode=1 and wraps from 0xFFFFFFFF to 0.

## Timing
- Forwarding, lu, branch and all stall/flush outputs are combinational from inputs and current state, with zero latency.
- A multi-cycle op occupies execute for exactly MC_LATENCY cycles:
  - 1 entry cycle, then MC_LATENCY-2 BUSY cycles, then 1 DONE cycle.
  - stall_execute is high for MC_LATENCY-1 of them.
- Back-to-back mc ops: the second enters execute at the DONE edge. IDLE sees it on the next cycle with no dead cycle and no re-trigger on the first op.
- reset (synchronous) sets state=IDLE, cnt=0, stall_cycles=0, including mid-op.
  - While reset is high every output is 0: selects 00, stalls 0, flushes 0, mc_done 0.
  - The first cycle after reset behaves per inputs.
- flush and stall are never both asserted for the same stage register.

## Test plan
- M dest x5 and W dest x5 both valid with rs1_addr_e=5 -> forward_rs1_select_e=10. With only W matching -> 01. With dest x0 -> 00.
- Load to x7 in execute, decode rs2_addr_d=7 -> one cycle of stall_fetch=1, stall_decode=1, flush_execute=1; next cycle all 0; stall_cycles +1.
- Load-use coincident with branch_taken_e -> flush_decode=1, flush_execute=1, stall_fetch=0, stall_decode=0.
- MC_LATENCY=32, mc_op_e pulse with valid_e -> stall_execute high for 31 cycles with flush_memory high; mc_done high on cycle 32; stall_cycles +31.
- Two consecutive mc ops -> 64 cycles total, mc_done pulses on cycles 32 and 64, never two consecutive mc_done.
- reset asserted on BUSY cycle 10 -> next cycle state IDLE, all outputs 0, stall_cycles=0.
